// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: answers "wFPGA,<addr>,<data>\n" / "rFPGA,<addr>\n" from a UART by driving a register bus.
// Define UART_CMD_BRIDGE_WRITE_ACK_EN to answer each completed write with "OK\n".
module uart_cmd_bridge #(
  parameter int AddrWidth   = 16,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_data_o,
  output logic                 bus_we_o,
  output logic                 bus_re_o,
  input  logic [DataWidth-1:0] bus_data_i,
  input  logic                 bus_busy_i,
  output logic                 err_o
);

  localparam logic [7:0] CharCr    = 8'h0D;
  localparam logic [7:0] CharLf    = 8'h0A;
  localparam logic [7:0] CharComma = 8'h2C;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DATA, DISCARD, BUS_WR, BUS_RD, FMT, SEND
  } state_e;

  state_e               state_q;
  logic [2:0]           matchIdx_q;
  logic                 isWrite_q;
  logic                 hasDigit_q;
  logic                 overflow_q;
  logic                 addrBad_q;
  logic [DataWidth-1:0] acc_q;
  logic [DataWidth-1:0] value_q;
  logic [AddrWidth-1:0] busAddr_q;
  logic [DataWidth-1:0] busData_q;
  logic                 busWe_q;
  logic                 busRe_q;
  logic                 rdWait_q;
  logic [7:0]           latCnt_q;
  logic [3:0]           powIdx_q;
  logic [3:0]           digCnt_q;
  logic                 started_q;
  logic [3:0]           len_q;
  logic [3:0]           txIdx_q;
  logic [7:0]           txBuf_q [11];
  logic                 txValid_q;
  logic                 err_q;

  logic                 isDigit_d;
  logic [DataWidth+3:0] accNext_d;
  logic                 carry_d;
  logic                 addrBig_d;
  logic                 lineOk_d;
  logic [DataWidth-1:0] pow_d;
  logic [7:0]           expected_d;

  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'd1000000000;
      4'd1:    return 32'd100000000;
      4'd2:    return 32'd10000000;
      4'd3:    return 32'd1000000;
      4'd4:    return 32'd100000;
      4'd5:    return 32'd10000;
      4'd6:    return 32'd1000;
      4'd7:    return 32'd100;
      4'd8:    return 32'd10;
      default: return 32'd1;
    endcase
  endfunction

  // acc*10 as two shifts in a 4-bit-wider intermediate so a carry out of the word is visible
  always_comb begin
    isDigit_d  = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
    accNext_d  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{DataWidth{1'b0}}, rx_data_i[3:0]};
    carry_d    = |accNext_d[DataWidth+3:DataWidth];
    addrBig_d  = (acc_q >> AddrWidth) != '0;
    lineOk_d   = hasDigit_q && !overflow_q && !((state_q == ADDR) ? addrBig_d : addrBad_q);
    pow_d      = DataWidth'(pow10(powIdx_q));
    case (matchIdx_q)
      3'd1:    expected_d = 8'h46;
      3'd2:    expected_d = 8'h50;
      3'd3:    expected_d = 8'h47;
      3'd4:    expected_d = 8'h41;
      3'd5:    expected_d = CharComma;
      default: expected_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      matchIdx_q <= '0;
      isWrite_q  <= 1'b0;
      hasDigit_q <= 1'b0;
      overflow_q <= 1'b0;
      addrBad_q  <= 1'b0;
      acc_q      <= '0;
      value_q    <= '0;
      busAddr_q  <= '0;
      busData_q  <= '0;
      busWe_q    <= 1'b0;
      busRe_q    <= 1'b0;
      rdWait_q   <= 1'b0;
      latCnt_q   <= '0;
      powIdx_q   <= '0;
      digCnt_q   <= '0;
      started_q  <= 1'b0;
      len_q      <= '0;
      txIdx_q    <= '0;
      txValid_q  <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 11; i++) txBuf_q[i] <= 8'h00;
    end else begin
      err_q <= rx_valid_i && (state_q inside {BUS_WR, BUS_RD, FMT, SEND});
      unique case (state_q)
        IDLE, CMD, ADDR, DATA, DISCARD: begin
          if (rx_valid_i && rx_data_i != CharCr) begin
            if (rx_data_i == CharLf) begin
              if (state_q == ADDR && !isWrite_q && lineOk_d) begin
                busAddr_q <= acc_q[AddrWidth-1:0];
                busRe_q   <= 1'b1;
                rdWait_q  <= 1'b0;
                state_q   <= BUS_RD;
              end else if (state_q == DATA && lineOk_d) begin
                busData_q <= acc_q;
                busWe_q   <= 1'b1;
                state_q   <= BUS_WR;
              end else if (state_q != IDLE) begin
                err_q      <= 1'b1;
                txBuf_q[0] <= 8'h45;
                txBuf_q[1] <= 8'h52;
                txBuf_q[2] <= 8'h52;
                txBuf_q[3] <= CharLf;
                len_q      <= 4'd4;
                txIdx_q    <= '0;
                txValid_q  <= 1'b1;
                state_q    <= SEND;
              end
            end else begin
              case (state_q)
                IDLE: begin
                  if (rx_data_i == 8'h77 || rx_data_i == 8'h72) begin
                    isWrite_q  <= (rx_data_i == 8'h77);
                    matchIdx_q <= 3'd1;
                    state_q    <= CMD;
                  end else begin
                    state_q <= DISCARD;
                  end
                end
                CMD: begin
                  if (rx_data_i != expected_d) begin
                    state_q <= DISCARD;
                  end else if (matchIdx_q == 3'd5) begin
                    acc_q      <= '0;
                    hasDigit_q <= 1'b0;
                    overflow_q <= 1'b0;
                    addrBad_q  <= 1'b0;
                    state_q    <= ADDR;
                  end else begin
                    matchIdx_q <= matchIdx_q + 3'd1;
                  end
                end
                ADDR: begin
                  if (isDigit_d) begin
                    acc_q      <= accNext_d[DataWidth-1:0];
                    hasDigit_q <= 1'b1;
                    overflow_q <= overflow_q | carry_d;
                  end else if (rx_data_i == CharComma && isWrite_q) begin
                    // the address verdict is kept until '\n' so the whole line is rejected at once
                    addrBad_q  <= !lineOk_d;
                    busAddr_q  <= acc_q[AddrWidth-1:0];
                    acc_q      <= '0;
                    hasDigit_q <= 1'b0;
                    overflow_q <= 1'b0;
                    state_q    <= DATA;
                  end else begin
                    state_q <= DISCARD;
                  end
                end
                DATA: begin
                  if (isDigit_d) begin
                    acc_q      <= accNext_d[DataWidth-1:0];
                    hasDigit_q <= 1'b1;
                    overflow_q <= overflow_q | carry_d;
                  end else begin
                    state_q <= DISCARD;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        BUS_WR: begin
          if (!bus_busy_i) begin
            busWe_q <= 1'b0;
`ifdef UART_CMD_BRIDGE_WRITE_ACK_EN
            txBuf_q[0] <= 8'h4F;
            txBuf_q[1] <= 8'h4B;
            txBuf_q[2] <= CharLf;
            len_q      <= 4'd3;
            txIdx_q    <= '0;
            txValid_q  <= 1'b1;
            state_q    <= SEND;
`else
            state_q <= IDLE;
`endif
          end
        end
        BUS_RD: begin
          if (!rdWait_q) begin
            if (!bus_busy_i) begin
              busRe_q  <= 1'b0;
              rdWait_q <= 1'b1;
              latCnt_q <= 8'(ReadLatency - 1);
            end
          end else if (latCnt_q == 8'd0) begin
            value_q   <= bus_data_i;
            powIdx_q  <= '0;
            digCnt_q  <= '0;
            started_q <= 1'b0;
            len_q     <= '0;
            state_q   <= FMT;
          end else begin
            latCnt_q <= latCnt_q - 8'd1;
          end
        end
        // one subtraction per cycle; a digit is emitted when its power of ten no longer fits
        FMT: begin
          if (value_q >= pow_d) begin
            value_q  <= value_q - pow_d;
            digCnt_q <= digCnt_q + 4'd1;
          end else begin
            digCnt_q <= '0;
            powIdx_q <= powIdx_q + 4'd1;
            if (started_q || digCnt_q != 4'd0 || powIdx_q == 4'd9) begin
              txBuf_q[len_q] <= {4'h3, digCnt_q};
              len_q          <= len_q + 4'd1;
              started_q      <= 1'b1;
            end
            if (powIdx_q == 4'd9) begin
              txBuf_q[len_q + 4'd1] <= CharLf;
              len_q                 <= len_q + 4'd2;
              txIdx_q               <= '0;
              txValid_q             <= 1'b1;
              state_q               <= SEND;
            end
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            if (txIdx_q == len_q - 4'd1) begin
              txValid_q <= 1'b0;
              txIdx_q   <= '0;
              state_q   <= IDLE;
            end else begin
              txIdx_q <= txIdx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data_o  = txBuf_q[txIdx_q];
  assign tx_valid_o = txValid_q;
  assign bus_addr_o = busAddr_q;
  assign bus_data_o = busData_q;
  assign bus_we_o   = busWe_q;
  assign bus_re_o   = busRe_q;
  assign err_o      = err_q;

endmodule
